// File: rtl/wave_pkg.sv
// Shared types for the wave sample RAM arbiter.
//   WAVE_ADDR_WIDTH : full wave RAM address width (MSB selects buffer half)
//   WAVE_DATA_WIDTH : sample width
//   wr_entry_t      : one queued capture write {addr, data}
package wave_pkg;

    localparam int WAVE_ADDR_WIDTH = 9;
    localparam int WAVE_DATA_WIDTH = 8;

    typedef struct packed {
        logic [WAVE_ADDR_WIDTH-1:0] addr;
        logic [WAVE_DATA_WIDTH-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/wave_ram_arbiter_if.sv
// Bus bundle between the wave RAM arbiter and its neighbours.
// Groups the capture write channel, the display read channel, the RAM port and
// the collision debug counter.
//   slave  : arbiter side
//   master : environment side (capture writer, display reader, RAM)
interface wave_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    // capture write channel
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    // display read channel
    logic                  read_index;
    logic                  rd_req;
    logic [ADDR_WIDTH-2:0] rd_addr;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    // single-port RAM
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    // debug
    logic [CNT_WIDTH-1:0]  collision_count;

    modport slave (
        input  wr_valid, wr_addr, wr_data, read_index, rd_req, rd_addr, ram_rdata,
        output wr_ready, rd_ready, rd_valid, rd_data, ram_addr, ram_we, ram_wdata,
               collision_count
    );

    modport master (
        output wr_valid, wr_addr, wr_data, read_index, rd_req, rd_addr, ram_rdata,
        input  wr_ready, rd_ready, rd_valid, rd_data, ram_addr, ram_we, ram_wdata,
               collision_count
    );

endinterface

// File: rtl/wave_wr_fifo.sv
// Two-entry synchronous skid FIFO for capture writes.
//   clk, reset : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : enqueue din (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   head       : oldest entry, valid while !empty
//   full/empty : occupancy flags
module wave_wr_fifo
    import wave_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wr_entry_t din,
    input  logic      pop,
    output wr_entry_t head,
    output logic      full,
    output logic      empty
);

    wr_entry_t  mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            // simultaneous push+pop leaves occupancy unchanged
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wave_ram_arbiter.sv
// Arbiter for the single-port wave sample RAM shared by the capture writer and
// the display reader. Display reads win by default; capture writes queue in a
// 2-entry FIFO and a read-streak limiter forces a write slot after
// MAX_READ_STREAK back-to-back reads while writes are waiting. Writes landing
// in the half the display currently owns are counted (saturating) for debug.
//   clk, reset : clock, synchronous active-low reset
//   bus        : write channel, read channel, RAM port, collision counter
// RAM signals are registered; read data returns two cycles after acceptance.
module wave_ram_arbiter
    import wave_pkg::*;
#(
    parameter int ADDR_WIDTH      = WAVE_ADDR_WIDTH,
    parameter int DATA_WIDTH      = WAVE_DATA_WIDTH,
    parameter int MAX_READ_STREAK = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic               clk,
    input  logic               reset,
    wave_ram_arbiter_if.slave  bus
);

    localparam int STREAK_W = $clog2(MAX_READ_STREAK + 1);

    // FIFO interface
    wr_entry_t push_entry;
    wr_entry_t head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      push;

    // arbitration
    logic      wr_ready;
    logic      rd_ready;
    logic      force_wr;
    logic      grant_rd;
    logic      grant_wr;
    logic      collide;

    // state
    logic [STREAK_W-1:0]   streak;
    logic [1:0]            vld_pipe;
    logic [CNT_WIDTH-1:0]  coll_cnt;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic                  ram_we_q;
    logic [DATA_WIDTH-1:0] ram_wdata_q;

    // ---------------------------------------------------------------- FIFO
    assign push_entry.addr = bus.wr_addr;
    assign push_entry.data = bus.wr_data;

    // Both ready outputs are held low during reset so nothing is accepted
    // into state that the reset edge is about to clear.
    assign wr_ready = reset && !fifo_full;
    assign push     = bus.wr_valid && wr_ready;

    wave_wr_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_entry),
        .pop   (grant_wr),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // --------------------------------------------------------- arbitration
    // The FIFO is never bypassed: a write pushed this cycle only becomes
    // visible as head on the next cycle, adding one cycle of write latency.
    assign force_wr = !fifo_empty && (streak == STREAK_W'(MAX_READ_STREAK));
    assign rd_ready = reset && !force_wr;
    assign grant_rd = bus.rd_req && rd_ready;
    assign grant_wr = !fifo_empty && !grant_rd;
    assign collide  = grant_wr && (head.addr[ADDR_WIDTH-1] == bus.read_index);

    // ------------------------------------------------------ registered side
    always_ff @(posedge clk) begin
        if (!reset) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            vld_pipe    <= '0;
            streak      <= '0;
            coll_cnt    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], grant_rd};
            ram_we_q <= grant_wr;

            // idle cycles keep address/data stable to avoid needless toggling
            if (grant_rd) begin
                ram_addr_q <= {bus.read_index, bus.rd_addr};
            end else if (grant_wr) begin
                ram_addr_q  <= head.addr;
                ram_wdata_q <= head.data;
            end

            // streak only matters while a write is waiting
            if (fifo_empty || grant_wr)
                streak <= '0;
            else if (grant_rd && streak != STREAK_W'(MAX_READ_STREAK))
                streak <= streak + STREAK_W'(1);

            // the write still proceeds; the counter is debug only
            if (collide && coll_cnt != '1)
                coll_cnt <= coll_cnt + CNT_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------- outputs
    assign bus.wr_ready        = wr_ready;
    assign bus.rd_ready        = rd_ready;
    assign bus.rd_valid        = vld_pipe[1];
    assign bus.rd_data         = bus.ram_rdata;
    assign bus.ram_addr        = ram_addr_q;
    assign bus.ram_we          = ram_we_q;
    assign bus.ram_wdata       = ram_wdata_q;
    assign bus.collision_count = coll_cnt;

endmodule

// File: tb/tb_wave_ram_arbiter.sv
// Self-checking bench for wave_ram_arbiter: directed scenarios followed by
// randomized traffic, a queue-based reference model and a decoupled monitor.
module tb_wave_ram_arbiter;

    localparam int MAXS = 4;

    typedef struct {
        logic [8:0] addr;
        logic [7:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wave_ram_arbiter_if #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();

    wave_ram_arbiter #(
        .ADDR_WIDTH(9), .DATA_WIDTH(8), .MAX_READ_STREAK(MAXS), .CNT_WIDTH(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model: read contents are a fixed function of the address
    function automatic logic [7:0] rom(input logic [8:0] a);
        return a[7:0] ^ (a[8] ? 8'h87 : 8'h5A);
    endfunction

    always @(posedge clk) bus.ram_rdata <= rom(bus.ram_addr);

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // reference model state
    ent_t        mq[$];      // writes waiting in the arbiter
    ent_t        sb_wr[$];   // scoreboard: writes expected on the RAM port
    logic [7:0]  sb_rd[$];   // scoreboard: read data expected on rd_data
    int          m_streak;
    logic        m_we;
    logic [8:0]  m_addr;
    logic [7:0]  m_wdata;
    logic [1:0]  m_vld;
    logic [15:0] m_cnt;

    function automatic void model_clear();
        mq.delete();
        sb_wr.delete();
        sb_rd.delete();
        m_streak = 0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_vld    = '0;
        m_cnt    = '0;
    endfunction

    // Monitor: whenever the DUT shows a RAM write or read data, pop and compare.
    always @(negedge clk) begin
        if (reset && bus.ram_we) begin
            if (sb_wr.size() == 0) begin
                chk("mon unexpected ram write", 32'(bus.ram_addr), 32'h1_0000);
            end else begin
                ent_t e;
                e = sb_wr.pop_front();
                chk("mon write addr", 32'(bus.ram_addr), 32'(e.addr));
                chk("mon write data", 32'(bus.ram_wdata), 32'(e.data));
            end
        end
        if (reset && bus.rd_valid) begin
            if (sb_rd.size() == 0) begin
                chk("mon unexpected rd_valid", 32'(bus.rd_data), 32'h1_0000);
            end else begin
                logic [7:0] d;
                d = sb_rd.pop_front();
                chk("mon rd_data", 32'(bus.rd_data), 32'(d));
            end
        end
    end

    // One clock of stimulus. Entered and left at posedge+1.
    task automatic cycle(input string tag, input logic wv, input logic [8:0] wa,
                         input logic [7:0] wd, input logic ri, input logic rq,
                         input logic [7:0] ra);
        logic e_wrdy, e_rrdy, g_rd, g_wr, psh, was_empty;
        ent_t h;
        bus.wr_valid   = wv;
        bus.wr_addr    = wa;
        bus.wr_data    = wd;
        bus.read_index = ri;
        bus.rd_req     = rq;
        bus.rd_addr    = ra;
        @(negedge clk);
        chk({tag, " ram_we"},    32'(bus.ram_we),          32'(m_we));
        chk({tag, " ram_addr"},  32'(bus.ram_addr),        32'(m_addr));
        chk({tag, " ram_wdata"}, 32'(bus.ram_wdata),       32'(m_wdata));
        chk({tag, " rd_valid"},  32'(bus.rd_valid),        32'(m_vld[1]));
        chk({tag, " coll_cnt"},  32'(bus.collision_count), 32'(m_cnt));

        was_empty = (mq.size() == 0);
        e_wrdy = (mq.size() < 2);
        e_rrdy = !(!was_empty && m_streak == MAXS);
        chk({tag, " wr_ready"}, 32'(bus.wr_ready), 32'(e_wrdy));
        chk({tag, " rd_ready"}, 32'(bus.rd_ready), 32'(e_rrdy));

        g_rd = rq && e_rrdy;
        g_wr = !was_empty && !g_rd;
        psh  = wv && e_wrdy;

        m_vld = {m_vld[0], g_rd};
        m_we  = g_wr;
        if (g_rd) begin
            m_addr = {ri, ra};
            sb_rd.push_back(rom({ri, ra}));
        end else if (g_wr) begin
            h       = mq.pop_front();
            m_addr  = h.addr;
            m_wdata = h.data;
            sb_wr.push_back(h);
            if (h.addr[8] == ri && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        if (was_empty || g_wr)   m_streak = 0;
        else if (g_rd)           m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        if (psh) mq.push_back('{addr: wa, data: wd});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input int n, input logic ri);
        for (int k = 0; k < n; k++) cycle(tag, 1'b0, 9'h0, 8'h0, ri, 1'b0, 8'h0);
    endtask

    // Reset held for three edges with wr_valid high. Entered/left at posedge+1.
    task automatic do_reset();
        reset        = 1'b0;
        bus.wr_valid = 1'b1;
        bus.rd_req   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset wr_ready", 32'(bus.wr_ready), 32'h0);
            chk("reset rd_ready", 32'(bus.rd_ready), 32'h0);
            if (k > 0) begin
                chk("reset ram_we",    32'(bus.ram_we),          32'h0);
                chk("reset ram_addr",  32'(bus.ram_addr),        32'h0);
                chk("reset ram_wdata", 32'(bus.ram_wdata),       32'h0);
                chk("reset rd_valid",  32'(bus.rd_valid),        32'h0);
                chk("reset coll_cnt",  32'(bus.collision_count), 32'h0);
            end
            @(posedge clk);
            #1;
            if (k == 0) model_clear();
        end
        reset        = 1'b1;
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        logic ri_r;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.read_index = 1'b0; bus.rd_req = 1'b0; bus.rd_addr = '0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // lone write into the idle half
        cycle("lone_wr", 1'b1, 9'h105, 8'h3C, 1'b0, 1'b0, 8'h00);
        idle("lone_wr", 3, 1'b0);

        // lone read from half 1, address 0x20 -> RAM 0x120
        cycle("lone_rd", 1'b0, 9'h000, 8'h00, 1'b1, 1'b1, 8'h20);
        idle("lone_rd", 3, 1'b1);

        // starvation guard: queue two writes then hold rd_req high
        cycle("starve", 1'b1, 9'h011, 8'h11, 1'b1, 1'b1, 8'h01);
        cycle("starve", 1'b1, 9'h022, 8'h22, 1'b1, 1'b1, 8'h02);
        for (int k = 0; k < 16; k++)
            cycle("starve", 1'b0, 9'h0, 8'h0, 1'b1, 1'b1, 8'(k + 3));
        idle("starve", 3, 1'b1);

        // backpressure and ordering: 5 write attempts under read pressure
        for (int k = 0; k < 5; k++)
            cycle("bp", 1'b1, 9'(9'h040 + k), 8'(8'hB0 + k), 1'b0, 1'b1, 8'(k));
        for (int k = 0; k < 12; k++)
            cycle("bp", 1'b0, 9'h0, 8'h0, 1'b0, 1'b1, 8'(k + 8'h80));
        idle("bp", 3, 1'b0);

        // collision into the display half
        cycle("coll", 1'b1, 9'h1FF, 8'h5E, 1'b1, 1'b0, 8'h00);
        idle("coll", 3, 1'b1);

        // saturation: preload the counter one below all-ones
        force dut.coll_cnt = 16'hFFFE;
        m_cnt = 16'hFFFE;
        idle("sat", 1, 1'b1);
        release dut.coll_cnt;
        idle("sat", 1, 1'b1);
        cycle("sat", 1'b1, 9'h1A0, 8'h01, 1'b1, 1'b0, 8'h00);
        cycle("sat", 1'b1, 9'h1A1, 8'h02, 1'b1, 1'b0, 8'h00);
        cycle("sat", 1'b1, 9'h1A2, 8'h03, 1'b1, 1'b0, 8'h00);
        idle("sat", 4, 1'b1);

        // clear the counter again before random traffic
        do_reset();

        ri_r = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            if ($urandom_range(0, 15) == 0) ri_r = ~ri_r;
            cycle("rand", 1'($urandom_range(0, 1)), 9'($urandom), 8'($urandom), ri_r,
                  ($urandom_range(0, 9) < 7), 8'($urandom));
        end
        idle("drain", 8, ri_r);

        chk("end writes outstanding", 32'(sb_wr.size()), 32'h0);
        chk("end reads outstanding",  32'(sb_rd.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
